// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry, counter
// widths and the receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = OVERSAMPLE / 2 - 1;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Typed compare values so the counters compare without width casts.
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(MID_TICK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Host-side view of the UART receiver: received byte, status flags and
// the acknowledge that clears them. The host is master, the core is slave.
interface uart_rx_core_if;
    import uart_pkg::*;

    logic                 rdy_clr;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rdy_clr,
        input  data, rdy, frame_err, overrun, busy
    );

    modport slave (
        input  rdy_clr,
        output data, rdy, frame_err, overrun, busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input. The reset value is
// a parameter so idle-high lines (RX, CTS) do not see a false edge at reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver clocked by a 16x oversampling tick. Validates the start
// bit at its midpoint, samples data bits mid-period LSB first, checks the
// stop bit and hands the byte to the host with sticky ready/overrun flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a low line on a tick
//   START | counting to mid start bit; line high there = false start
//   DATA  | sampling one data bit every OVERSAMPLE ticks
//   STOP  | sampling the stop bit, then publishing the byte
module uart_rx_core
    import uart_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_enb,
    input  logic          rx,
    uart_rx_core_if.slave host
);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     sample_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_q;
    logic                 rdy_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Receive FSM with its counters and the registered host-side flags.
    // The host clear is applied first so a completion in the same cycle
    // overrides it, while overrun still captures the pre-clear rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (host.rdy_clr) begin
                rdy_q     <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (rx_enb) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state      <= START;
                            sample_cnt <= '0;
                        end
                    end
                    START: begin
                        if (sample_cnt != MID_CNT) begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end else if (!rx_s) begin
                            state      <= DATA;
                            sample_cnt <= '0;
                            bit_idx    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (sample_cnt == LAST_CNT) begin
                            shift_reg[bit_idx] <= rx_s;
                            sample_cnt         <= '0;
                            if (bit_idx == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (sample_cnt == LAST_CNT) begin
                            // Leaving at mid-stop lets an immediately
                            // following start bit be caught.
                            data_q      <= shift_reg;
                            rdy_q       <= 1'b1;
                            frame_err_q <= ~rx_s;
                            overrun_q   <= rdy_q;
                            state       <= IDLE;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Drive the host-side view from the registered flags.
    always_comb begin
        host.data      = data_q;
        host.rdy       = rdy_q;
        host.frame_err = frame_err_q;
        host.overrun   = overrun_q;
        host.busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: rx_enb every 4 clk, 64 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int BIT_CLKS = 4 * OVERSAMPLE;

    logic clk = 1'b0;
    logic rst;
    logic rx_enb;
    logic rx;
    logic got_rdy;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx_core_if u_if ();

    uart_rx_core dut (
        .clk    (clk),
        .rst    (rst),
        .rx_enb (rx_enb),
        .rx     (rx),
        .host   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        rx_enb = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_enb = 1'b1;
            @(negedge clk);
            rx_enb = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first; returns at the stop bit.
    task automatic drive_bits(input logic [7:0] b);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_clks);
        drive_bits(b);
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(idle_clks);
    endtask

    task automatic pulse_clr();
        u_if.rdy_clr = 1'b1;
        @(negedge clk);
        u_if.rdy_clr = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        rx           = 1'b1;
        u_if.rdy_clr = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);

        chk("reset_data",      u_if.data,      0);
        chk("reset_rdy",       u_if.rdy,       0);
        chk("reset_frame_err", u_if.frame_err, 0);
        chk("reset_overrun",   u_if.overrun,   0);
        chk("reset_busy",      u_if.busy,      0);

        send_frame(8'hA5, 1'b1, 16);
        chk("a5_data",      u_if.data,      32'hA5);
        chk("a5_rdy",       u_if.rdy,       1);
        chk("a5_frame_err", u_if.frame_err, 0);
        chk("a5_overrun",   u_if.overrun,   0);
        chk("a5_busy",      u_if.busy,      0);

        pulse_clr();
        chk("clr_rdy", u_if.rdy, 0);

        // Glitch: 3 ticks low, then back high before the mid-start check.
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        chk("glitch_busy_high", u_if.busy, 1);
        wait_clks(48);
        chk("glitch_busy_low", u_if.busy, 0);
        chk("glitch_rdy",      u_if.rdy,  0);
        chk("glitch_data",     u_if.data, 32'hA5);

        send_frame(8'h3C, 1'b0, 32);
        chk("bad_stop_data",      u_if.data,      32'h3C);
        chk("bad_stop_rdy",       u_if.rdy,       1);
        chk("bad_stop_frame_err", u_if.frame_err, 1);
        chk("bad_stop_busy",      u_if.busy,      0);

        send_frame(8'h3C, 1'b1, 16);
        chk("good_stop_data",      u_if.data,      32'h3C);
        chk("good_stop_frame_err", u_if.frame_err, 0);

        pulse_clr();
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 16);
        chk("ovr_data",      u_if.data,      32'h22);
        chk("ovr_rdy",       u_if.rdy,       1);
        chk("ovr_overrun",   u_if.overrun,   1);
        chk("ovr_frame_err", u_if.frame_err, 0);
        pulse_clr();
        chk("ovr_clr_rdy",     u_if.rdy,     0);
        chk("ovr_clr_overrun", u_if.overrun, 0);
        chk("ovr_clr_data",    u_if.data,    32'h22);

        // Reset in the middle of data bit 4 of 0xFF.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end
        wait_clks(BIT_CLKS / 2);
        chk("rst_mid_busy_before", u_if.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_data",      u_if.data,      0);
        chk("rst_mid_rdy",       u_if.rdy,       0);
        chk("rst_mid_frame_err", u_if.frame_err, 0);
        chk("rst_mid_overrun",   u_if.overrun,   0);
        chk("rst_mid_busy",      u_if.busy,      0);
        wait_clks(4 * BIT_CLKS);
        chk("rst_idle_rdy", u_if.rdy, 0);

        send_frame(8'h5A, 1'b1, 16);
        chk("post_rst_data", u_if.data, 32'h5A);
        chk("post_rst_rdy",  u_if.rdy,  1);

        // Assert rdy_clr on every tick through the stop bit; the tick where
        // rdy rises is by construction coincident with the clear.
        pulse_clr();
        drive_bits(8'h81);
        rx      = 1'b1;
        got_rdy = 1'b0;
        for (int k = 0; k < 2 * BIT_CLKS && !got_rdy; k++) begin
            @(negedge clk);
            #1;
            if (rx_enb) begin
                u_if.rdy_clr = 1'b1;
                @(posedge clk);
                #1;
                u_if.rdy_clr = 1'b0;
                if (u_if.rdy) got_rdy = 1'b1;
            end
        end
        chk("coincide_rdy",     got_rdy,      1);
        chk("coincide_data",    u_if.data,    32'h81);
        chk("coincide_overrun", u_if.overrun, 0);
        wait_clks(BIT_CLKS);
        chk("coincide_busy", u_if.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
